// File: rtl/alu_seq_pkg.sv
// Shared opcode map, opcode type and controller state encoding for alu_seq.
package alu_seq_pkg;

    typedef logic [3:0] op_t;

    localparam op_t OP_ADD = 4'd0;
    localparam op_t OP_SUB = 4'd1;
    localparam op_t OP_INC = 4'd2;
    localparam op_t OP_DEC = 4'd3;
    localparam op_t OP_MUL = 4'd4;
    localparam op_t OP_AND = 4'd5;
    localparam op_t OP_OR  = 4'd6;
    localparam op_t OP_XOR = 4'd7;
    localparam op_t OP_NOT = 4'd8;
    localparam op_t OP_SHL = 4'd9;
    localparam op_t OP_SHR = 4'd10;
    localparam op_t OP_LT  = 4'd11;
    localparam op_t OP_GT  = 4'd12;

    typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative unsigned shift-add multiplier: one multiplier bit per cycle, LSB of b first.
// done flags the final iteration; product carries that iteration's result combinationally.
module alu_seq_mul #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           done,
    output logic [2*W-1:0] product
);
    localparam int CNT_W = $clog2(W) + 1;

    logic [2*W-1:0]   prod_q, prod_d, step;
    logic [W-1:0]     mcand_q, mcand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W:0]       upper;

    // Low half starts as the multiplier and is shifted out as the product shifts in.
    always_comb begin
        upper   = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, mcand_q} : {(W+1){1'b0}});
        step    = {upper, prod_q[W-1:1]};
        prod_d  = prod_q;
        mcand_d = mcand_q;
        cnt_d   = cnt_q;
        if (start) begin
            prod_d  = {{W{1'b0}}, b};
            mcand_d = a;
            cnt_d   = CNT_W'(W);
        end else if (cnt_q != '0) begin
            prod_d = step;
            cnt_d  = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q  <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
        end else begin
            prod_q  <= prod_d;
            mcand_q <= mcand_d;
            cnt_q   <= cnt_d;
        end
    end

    assign done    = (cnt_q == CNT_W'(1));
    assign product = step;

endmodule

// File: rtl/alu_seq.sv
// Handshaked, registered W-bit ALU with carry/zero/overflow/error flags.
// Define ALU_SEQ_MUL_EN to build the iterative 2W-bit multiplier for op 4; otherwise op 4 is illegal.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [3:0]   op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic [W-1:0] result_hi,
    output logic         carry,
    output logic         zero,
    output logic         ovf,
    output logic         err
);
    state_t       state_q, state_d;
    logic         rdy_en_q;
    logic [W-1:0] a_q, a_d, b_q, b_d;
    op_t          op_q, op_d;
    logic [W-1:0] result_q, result_d, result_hi_q, result_hi_d;
    logic         carry_q, carry_d, zero_q, zero_d, ovf_q, ovf_d, err_q, err_d;
    logic         accept, exec_ld;
    logic [W:0]   sum_w, diff_w, inc_w, dec_w;
    logic [W-1:0] alu_res;
    logic         alu_carry, alu_ovf, alu_err;

`ifdef ALU_SEQ_MUL_EN
    logic           mul_done, mul_ld;
    logic [2*W-1:0] mul_prod;

    alu_seq_mul #(.W(W)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (accept && (op == OP_MUL)),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_prod)
    );
    assign mul_ld = (state_q == MUL) && mul_done;
`endif

    // rdy_en_q keeps in_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rdy_en_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
`ifdef ALU_SEQ_MUL_EN
            IDLE:    if (accept) state_d = (op == OP_MUL) ? MUL : EXEC;
            MUL:     if (mul_done) state_d = DONE;
`else
            IDLE:    if (accept) state_d = EXEC;
`endif
            EXEC:    state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE) && rdy_en_q;
        out_valid = (state_q == DONE);
        exec_ld   = (state_q == EXEC);
    end

    assign accept = in_valid && in_ready;

    always_comb begin
        sum_w     = {1'b0, a_q} + {1'b0, b_q};
        diff_w    = {1'b0, a_q} - {1'b0, b_q};
        inc_w     = {1'b0, a_q} + {{W{1'b0}}, 1'b1};
        dec_w     = {1'b0, a_q} - {{W{1'b0}}, 1'b1};
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        alu_err   = 1'b0;
        case (op_q)
            OP_ADD: begin
                alu_res   = sum_w[W-1:0];
                alu_carry = sum_w[W];
                alu_ovf   = (a_q[W-1] == b_q[W-1]) && (sum_w[W-1] != a_q[W-1]);
            end
            OP_SUB: begin
                alu_res   = diff_w[W-1:0];
                alu_carry = diff_w[W];
                alu_ovf   = (a_q[W-1] != b_q[W-1]) && (diff_w[W-1] != a_q[W-1]);
            end
            OP_INC: begin
                alu_res   = inc_w[W-1:0];
                alu_carry = inc_w[W];
                alu_ovf   = !a_q[W-1] && inc_w[W-1];
            end
            OP_DEC: begin
                alu_res   = dec_w[W-1:0];
                alu_carry = dec_w[W];
                alu_ovf   = a_q[W-1] && !dec_w[W-1];
            end
            OP_AND: alu_res = a_q & b_q;
            OP_OR:  alu_res = a_q | b_q;
            OP_XOR: alu_res = a_q ^ b_q;
            OP_NOT: alu_res = ~a_q;
            OP_SHL: begin
                alu_res   = {a_q[W-2:0], 1'b0};
                alu_carry = a_q[W-1];
            end
            OP_SHR: begin
                alu_res   = {1'b0, a_q[W-1:1]};
                alu_carry = a_q[0];
            end
            OP_LT:   alu_res = {{(W-1){1'b0}}, (a_q < b_q)};
            OP_GT:   alu_res = {{(W-1){1'b0}}, (a_q > b_q)};
            default: alu_err = 1'b1;
        endcase
    end

    // Result registers only change on a load, so DONE holds them stable under backpressure.
    always_comb begin
        a_d         = accept ? a : a_q;
        b_d         = accept ? b : b_q;
        op_d        = accept ? op : op_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        carry_d     = carry_q;
        zero_d      = zero_q;
        ovf_d       = ovf_q;
        err_d       = err_q;
        if (exec_ld) begin
            result_d    = alu_res;
            result_hi_d = '0;
            carry_d     = alu_carry;
            ovf_d       = alu_ovf;
            err_d       = alu_err;
            zero_d      = (alu_res == '0);
        end
`ifdef ALU_SEQ_MUL_EN
        else if (mul_ld) begin
            result_d    = mul_prod[W-1:0];
            result_hi_d = mul_prod[2*W-1:W];
            carry_d     = 1'b0;
            ovf_d       = 1'b0;
            err_d       = 1'b0;
            zero_d      = (mul_prod == '0);
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            result_q    <= '0;
            result_hi_q <= '0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            carry_q     <= carry_d;
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
            err_q       <= err_d;
        end
    end

    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign carry     = carry_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;
    assign err       = err_q;

endmodule
